// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encryption controller slice.
package aes_pkg;

  localparam int unsigned AES_ROUNDS = 10;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned SCHED_W    = 1408;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KRST,
    ST_KSTART,
    ST_KWAIT,
    ST_ROUND,
    ST_DONE
  } ctrl_state_e;

  // Round r key lives at sched[SCHED_W-1-KEY_W*r -: KEY_W]; out-of-range r yields zero.
  function automatic logic [KEY_W-1:0] round_key(input logic [SCHED_W-1:0] sched,
                                                 input logic [3:0]         r);
    logic [SCHED_W-1:0] sh;
    if (r > 4'(AES_ROUNDS)) return '0;
    sh = sched >> (KEY_W * (AES_ROUNDS - 32'(r)));
    return sh[KEY_W-1:0];
  endfunction

endpackage

// File: rtl/aes_key_cache.sv
// Holds the key of the most recently expanded schedule and whether it is still valid.
module aes_key_cache
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             set_ok,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_q,
  output logic             key_ok,
  output logic             hit
);

  // A flush in the same cycle as a lookup forces a miss.
  assign hit = key_ok && !flush && (key_in == key_q);

  // Key capture on accept; validity cleared by flush or miss, set once expansion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      key_ok <= 1'b0;
    end else begin
      if (load) key_q <= key_in;
      if (flush || (load && !hit)) key_ok <= 1'b0;
      else if (set_ok)             key_ok <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_encrypt_ctrl.sv
// Sequencing controller for one AES-128 encryption core with an expanded-key cache.
module aes_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned KE_WAIT = 64
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KEY_W-1:0]   in_key,
  input  logic [KEY_W-1:0]   in_block,
  input  logic               key_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KEY_W-1:0]   out_block,
  output logic [KEY_W-1:0]   ke_key,
  output logic               ke_start,
  output logic               ke_rst,
  input  logic               ke_finish,
  input  logic [SCHED_W-1:0] ke_keys,
  output logic [KEY_W-1:0]   rd_state,
  output logic [KEY_W-1:0]   rd_key,
  output logic [3:0]         rd_round,
  output logic               rd_last,
  input  logic [KEY_W-1:0]   rd_result
);

  // wcnt saturates at 127, so KE_WAIT above 128 can never be satisfied.
  localparam int unsigned WAIT_MIN = (KE_WAIT == 0) ? 0 : KE_WAIT - 1;

  ctrl_state_e      fsm, fsm_nxt;
  logic [KEY_W-1:0] state, state_nxt;
  logic [KEY_W-1:0] block_q, block_nxt;
  logic [3:0]       round, round_nxt;
  logic [6:0]       wcnt, wcnt_nxt;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] rk0;
  logic             key_ok;
  logic             hit;
  logic             load;
  logic             set_ok;
  logic             wait_done;

  aes_key_cache u_cache (
    .clk    (clk),
    .rst    (rst),
    .flush  (key_flush),
    .load   (load),
    .set_ok (set_ok),
    .key_in (in_key),
    .key_q  (key_q),
    .key_ok (key_ok),
    .hit    (hit)
  );

  assign rk0       = round_key(ke_keys, 4'd0);
  assign wait_done = (32'(wcnt) >= WAIT_MIN);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= ST_IDLE;
      state   <= '0;
      block_q <= '0;
      round   <= '0;
      wcnt    <= '0;
    end else begin
      fsm     <= fsm_nxt;
      state   <= state_nxt;
      block_q <= block_nxt;
      round   <= round_nxt;
      wcnt    <= wcnt_nxt;
    end
  end

  // Next-state and register update decode.
  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state;
    block_nxt = block_q;
    round_nxt = round;
    wcnt_nxt  = wcnt;
    load      = 1'b0;
    set_ok    = 1'b0;
    case (fsm)
      ST_IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          block_nxt = in_block;
          if (hit) begin
            state_nxt = in_block ^ rk0;
            round_nxt = 4'd1;
            fsm_nxt   = ST_ROUND;
          end else begin
            fsm_nxt   = ST_KRST;
          end
        end
      end
      ST_KRST: fsm_nxt = ST_KSTART;
      ST_KSTART: begin
        wcnt_nxt = '0;
        fsm_nxt  = ST_KWAIT;
      end
      ST_KWAIT: begin
        if (wcnt != '1) wcnt_nxt = wcnt + 7'd1;
        // ke_finish may be stale from a previous key; only trust it after the minimum wait.
        if (wait_done && ke_finish) begin
          set_ok    = 1'b1;
          state_nxt = block_q ^ rk0;
          round_nxt = 4'd1;
          fsm_nxt   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_nxt = rd_result;
        round_nxt = round + 4'd1;
        if (round == 4'(AES_ROUNDS)) fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_nxt = ST_IDLE;
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = (fsm == ST_IDLE);
  assign out_valid = (fsm == ST_DONE);
  assign out_block = state;
  assign ke_key    = key_q;
  assign ke_rst    = rst | (fsm == ST_KRST);
  assign ke_start  = (fsm == ST_KSTART) || (fsm == ST_KWAIT);
  assign rd_state  = state;
  assign rd_key    = round_key(ke_keys, round);
  assign rd_round  = round;
  assign rd_last   = (round == 4'(AES_ROUNDS));

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Randomized self-checking bench for aes_encrypt_ctrl with behavioural AES expander/round models.
module tb_aes_encrypt_ctrl;
  import aes_pkg::*;

  localparam int unsigned KE_WAIT = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [KEY_W-1:0]    in_key;
  logic [KEY_W-1:0]    in_block;
  logic                key_flush;
  logic                out_valid;
  logic                out_ready;
  logic [KEY_W-1:0]    out_block;
  logic [KEY_W-1:0]    ke_key;
  logic                ke_start;
  logic                ke_rst;
  logic                ke_finish = 1'b0;
  logic [SCHED_W-1:0]  ke_keys = '0;
  logic [KEY_W-1:0]    rd_state;
  logic [KEY_W-1:0]    rd_key;
  logic [3:0]          rd_round;
  logic                rd_last;
  logic [KEY_W-1:0]    rd_result;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_t [256];

  aes_encrypt_ctrl #(.KE_WAIT(KE_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_block  (in_block),
    .key_flush (key_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .ke_key    (ke_key),
    .ke_start  (ke_start),
    .ke_rst    (ke_rst),
    .ke_finish (ke_finish),
    .ke_keys   (ke_keys),
    .rd_state  (rd_state),
    .rd_key    (rd_key),
    .rd_round  (rd_round),
    .rd_last   (rd_last),
    .rd_result (rd_result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [7:0] x;
      logic [7:0] inv;
      x   = 8'(v);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = a[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(8'h02, c0) ^ gmul(8'h03, c1) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gmul(8'h02, c1) ^ gmul(8'h03, c2) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gmul(8'h02, c2) ^ gmul(8'h03, c3);
        b[4*c+3] = gmul(8'h03, c0) ^ c1 ^ c2 ^ gmul(8'h02, c3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] sch;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) sch[1407-32*i -: 32] = w[i];
    return sch;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] sch;
    logic [127:0]  s;
    sch = key_expand(key);
    s   = pt ^ sch[1407 -: 128];
    for (int r = 1; r <= 10; r++) s = aes_round(s, sch[1407-128*r -: 128], r == 10);
    return s;
  endfunction

  // Combinational single-round datapath seen by the controller.
  assign rd_result = aes_round(rd_state, rd_key, rd_last);

  // ---------------- key expander model ----------------
  bit sticky;      // when set, ke_finish survives ke_rst (stale finish from an earlier key)
  int exp_lat;
  logic prev_start = 1'b0;
  logic busy = 1'b0;
  int   cnt = 0;

  always @(posedge clk) begin
    prev_start <= ke_start;
    if (ke_rst) begin
      busy <= 1'b0;
      if (!sticky) ke_finish <= 1'b0;
    end else if (ke_start && !prev_start) begin
      if (!sticky) ke_keys <= {44{$urandom}};
      busy <= 1'b1;
      cnt  <= exp_lat;
    end else if (busy) begin
      if (cnt == 0) begin
        ke_keys   <= key_expand(ke_key);
        ke_finish <= 1'b1;
        busy      <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // ---------------- activity monitors ----------------
  int krst_cnt = 0;
  int kstart_cnt = 0;
  always @(negedge clk) begin
    if (ke_rst && !rst) krst_cnt <= krst_cnt + 1;
    if (ke_start)       kstart_cnt <= kstart_cnt + 1;
  end

  // ---------------- reference cache model ----------------
  logic [127:0] model_key = '0;
  bit           model_ok  = 1'b0;
  int           kr0, ks0;

  task automatic send(input logic [127:0] key, input logic [127:0] pt, input bit flush);
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check_val("in_ready_to", 128'(in_ready), 128'(1));
    kr0       = krst_cnt;
    ks0       = kstart_cnt;
    in_valid  = 1'b1;
    in_key    = key;
    in_block  = pt;
    key_flush = flush;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    key_flush = 1'b0;
  endtask

  task automatic collect(input logic [127:0] key, input logic [127:0] pt, input bit exp_hit,
                         input int hold, input bit has_fixed, input logic [127:0] fixed_ct,
                         input bit exact_wait);
    logic [1407:0] sch;
    logic [127:0]  held;
    int            edges, ks, kr, n;
    bit            stable;
    sch   = key_expand(key);
    edges = 1;
    while (!out_valid && edges < 600) begin
      if (!ke_rst && !ke_start && !in_ready && rd_round >= 4'd1 && rd_round <= 4'd10) begin
        check_val("rd_key", rd_key, round_key(sch, rd_round));
        check_val("rd_last", 128'(rd_last), 128'(rd_round == 4'd10));
      end
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) check_val("ov_timeout", 128'(out_valid), 128'(1));
    ks = kstart_cnt - ks0;
    kr = krst_cnt - kr0;
    if (exp_hit) begin
      check_val("hit_krst", 128'(kr), 128'(0));
      check_val("hit_kstart", 128'(ks), 128'(0));
      check_val("hit_lat", 128'(edges), 128'(11));
    end else begin
      n = ks - 1;
      check_val("miss_krst", 128'(kr), 128'(1));
      check_val("miss_lat", 128'(edges), 128'(13 + n));
      if (exact_wait) check_val("kwait_len", 128'(n), 128'(KE_WAIT));
      else            check_val("kwait_min", 128'(n >= int'(KE_WAIT)), 128'(1));
    end
    check_val("ct_model", out_block, aes_ref(key, pt));
    if (has_fixed) check_val("ct_fips", out_block, fixed_ct);
    held   = out_block;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_block !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check_val("hold_stable", 128'(stable), 128'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("hs_ov", 128'(out_valid), 128'(0));
    check_val("hs_idle", 128'(in_ready), 128'(1));
  endtask

  task automatic do_block(input logic [127:0] key, input logic [127:0] pt, input bit flush,
                          input int hold, input bit has_fixed, input logic [127:0] fixed_ct,
                          input bit exact_wait);
    bit exp_hit;
    exp_hit = model_ok && !flush && (key == model_key);
    send(key, pt, flush);
    collect(key, pt, exp_hit, hold, has_fixed, fixed_ct, exact_wait);
    model_ok  = 1'b1;
    model_key = key;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k1, p1, c1, k2, p2, c2, rk, rp;
    bit           seen_ov, fl;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    p1 = 128'h00112233445566778899aabbccddeeff;
    c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    p2 = 128'h3243f6a8885a308d313198a2e0370734;
    c2 = 128'h3925841d02dc09fbdc118597196a0b32;

    rst = 1'b1; in_valid = 1'b0; in_key = '0; in_block = '0; key_flush = 1'b0;
    out_ready = 1'b0; sticky = 1'b0; exp_lat = 3;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ke_rst", 128'(ke_rst), 128'(1));
    check_val("rst_ov", 128'(out_valid), 128'(0));
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", 128'(in_ready), 128'(1));
    check_val("rst_ke_start", 128'(ke_start), 128'(0));
    check_val("rst_ke_rst_lo", 128'(ke_rst), 128'(0));
    check_val("rst_round", 128'(rd_round), 128'(0));
    check_val("rst_state", rd_state, 128'(0));
    check_val("rst_outblk", out_block, 128'(0));

    // FIPS-197 C.1, then a cache hit with a long consumer stall.
    do_block(k1, p1, 1'b0, 0, 1'b1, c1, 1'b0);
    do_block(k1, '0, 1'b0, 20, 1'b0, '0, 1'b0);

    // New key while ke_finish is still high from the previous expansion.
    sticky = 1'b1; exp_lat = 5;
    check_val("stale_finish", 128'(ke_finish), 128'(1));
    do_block(k2, p2, 1'b0, 2, 1'b1, c2, 1'b1);
    sticky = 1'b0; exp_lat = 30;

    // Flush together with a cached key forces re-expansion.
    do_block(k2, p2, 1'b1, 0, 1'b1, c2, 1'b0);

    // Reset in the middle of a hit block.
    send(k2, p1, 1'b0);
    for (int i = 0; i < 50 && rd_round != 4'd5; i++) begin
      @(posedge clk); #1;
    end
    check_val("mid_round5", 128'(rd_round), 128'(5));
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_ke_rst", 128'(ke_rst), 128'(1));
    check_val("mid_idle", 128'(in_ready), 128'(1));
    check_val("mid_ov", 128'(out_valid), 128'(0));
    rst = 1'b0;
    model_ok = 1'b0;
    seen_ov = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen_ov = 1'b1;
    end
    check_val("mid_no_ov", 128'(seen_ov), 128'(0));
    do_block(k2, p2, 1'b0, 0, 1'b1, c2, 1'b0);

    // Randomized traffic with key reuse, flushes and variable expander latency.
    for (int it = 0; it < 12; it++) begin
      if (model_ok && $urandom_range(0, 1) == 1) rk = model_key;
      else rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      fl = ($urandom_range(0, 4) == 0);
      exp_lat = int'($urandom_range(0, KE_WAIT + 8));
      do_block(rk, rp, fl, int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_encrypt_ctrl.md
# aes_encrypt_ctrl

Sequencing controller for one AES-128 encryption core. It accepts a key/plaintext pair over a valid/ready handshake and drives the `keyexpansion` block. It then steps an external single-round combinational datapath through rounds 1..10 and returns the ciphertext over a second valid/ready handshake. The most recent expanded key is cached, so back-to-back blocks under the same key skip re-expansion.

## Interface
Parameters:
- `KE_WAIT`, default 64: minimum number of cycles spent in KWAIT before `ke_finish` is honoured.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: key/block offered.
- `in_ready`  out  1: controller can accept.
- `in_key`  in  128: cipher key, byte 0 in bits [127:120].
- `in_block`  in  128: plaintext, same byte order.
- `key_flush`  in  1: one-cycle pulse that invalidates the key cache.
- `out_valid`  out  1: ciphertext available.
- `out_ready`  in  1: consumer accepts.
- `out_block`  out  128: ciphertext.
- `ke_key`  out  128: key presented to the expander.
- `ke_start`  out  1: expander start.
- `ke_rst`  out  1: expander reset.
- `ke_finish`  in  1: expander done. This is a level; it may remain high from an earlier key.
- `ke_keys`  in  1408: expanded schedule. Round r key is `ke_keys[1407-128*r -: 128]`.
- `rd_state`  out  128: state fed to the round datapath.
- `rd_key`  out  128: round key for `rd_round`.
- `rd_round`  out  4: current round, 1..10.
- `rd_last`  out  1: high when `rd_round`==10 (omit MixColumns).
- `rd_result`  in  128: combinational round output.

## Operation
FSM states are IDLE, KRST, KSTART, KWAIT, ROUND, DONE. Registers are `state` (128), `key_q` (128), `key_ok` (1), `round` (4) and `wcnt` (7).

- **IDLE:** `in_ready`=1. On `in_valid`, latch `in_block` and `in_key` into `key_q`.
  - Cache hit (`key_ok` and `in_key`==`key_q`): set `state` ← `in_block` ^ rk0, `round` ← 1, go to ROUND.
  - Otherwise: clear `key_ok` and go to KRST.
- **key_flush:** clears `key_ok` in any state. In IDLE it takes effect before the hit compare, so flush together with `in_valid` in the same cycle forces a miss.
- **KRST:** `ke_rst`=1 for exactly one cycle, then KSTART.
- **KSTART:** `ke_start`=1 and `wcnt` ← 0, then KWAIT.
- **KWAIT:** `ke_start` stays 1 and `wcnt` increments, saturating.
  - Exit condition: `wcnt` ≥ `KE_WAIT`−1 and `ke_finish`=1.
  - On exit: `key_ok` ← 1, `state` ← `block_q` ^ rk0, `round` ← 1, go to ROUND.
- **ROUND:** each cycle `state` ← `rd_result` and `round` ← `round`+1. On the cycle with `round`==10, go to DONE.
- **DONE:** `out_valid`=1 and `out_block`=`state`, held stable until `out_ready`. On `out_valid`&`out_ready`, go to IDLE.
- `ke_key` is `key_q` at all times. `rd_state` is `state` and `rd_key` is the slice for `round`.
- `in_ready` is 0 outside IDLE; there is no input buffering.

## Timing
- Reset values: FSM=IDLE, `key_ok`=0, `out_valid`=0, `ke_start`=0, `round`=0, `state`=0. `ke_rst`=1 while `rst` is high (`ke_rst` = `rst` | KRST). `in_ready`=1 from the first cycle after reset.
- Reset mid-operation: any state returns to IDLE and the cache is invalidated; no `out_valid` is produced for the aborted block.
- Cache-hit latency: `out_valid` rises 11 cycles after the accepting edge, covering 10 ROUND cycles plus the entry edge.
- Miss latency: 2 + (cycles spent in KWAIT) + 11.
- `out_block` is held unchanged while `out_valid`&!`out_ready`.
- In DONE, `in_valid` is ignored. A new transfer may be accepted on the cycle after the handshake.
- All outputs are registered or decoded from the FSM/registers only. There are no combinational paths from `in_*` or `out_ready` to outputs, except `in_ready`, which is a state decode.

## Structure
- Shared package `aes_pkg` holds:
  - the state encoding;
  - `AES_ROUNDS`=10;
  - `KEY_W`=128 and `SCHED_W`=1408;
  - a `round_key(sched, r)` slice function, also used by the bench.
- One sub-module, `aes_key_cache`: `key_q`/`key_ok` with the compare and flush logic.

## Test plan
- FIPS-197 C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a. Exactly one KRST pulse.
- Same key again with pt 00…00 → no `ke_rst`/`ke_start` activity; `out_valid` exactly 11 cycles after acceptance; result matches the model.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
  - Run this with `ke_finish` already high from the previous key.
  - KWAIT must last ≥ `KE_WAIT` cycles.
- Hold `out_ready`=0 for 20 cycles in DONE → `out_block` stable and `in_ready`=0. Release → handshake in one cycle, then IDLE.
- `key_flush` asserted together with `in_valid` carrying the cached key → miss path taken (`ke_rst` pulses) and the correct ciphertext is produced.
- `rst` asserted at ROUND `round`=5 → next cycle IDLE, `out_valid`=0, `key_ok`=0. The next block with the old key re-expands.
